// File: rtl/byte_frame_packer.sv
// byte_frame_packer
// Pulls payload bytes from the clk_out side of the dual-clock FIFO. Each
// PKT_LEN-byte group is wrapped as 0x55, 0xD5, LEN, payload, CSUM and sent
// on a registered valid/ready byte stream. If the source starves for TIMEOUT
// output-advancing cycles mid-frame, the rest of the payload is filled with
// PAD_BYTE so the frame still completes.

module byte_frame_packer #(
    parameter int unsigned PKT_LEN  = 16,
    parameter int unsigned TIMEOUT  = 64,
    parameter logic [7:0]  PAD_BYTE = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  din,
    input  logic        din_vld,
    output logic        din_rdy,
    output logic [7:0]  dout,
    output logic        dout_vld,
    output logic        dout_sop,
    output logic        dout_eop,
    input  logic        dout_rdy,
    output logic [15:0] frm_cnt,
    output logic        timeout_pulse
);

    localparam int unsigned     TW         = $clog2(TIMEOUT + 1);
    localparam logic [7:0]      LEN_BYTE   = 8'(PKT_LEN);
    localparam logic [7:0]      LAST_IDX   = 8'(PKT_LEN - 1);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_H1   = 3'd1,
        S_LEN  = 3'd2,
        S_DATA = 3'd3,
        S_PAD  = 3'd4,
        S_CSUM = 3'd5
    } state_t;

    // Modulo-256 running checksum over payload and pad bytes.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    state_t         state_r, state_s;
    logic [7:0]     dout_r, dout_s;
    logic           vld_r, vld_s;
    logic           sop_r, sop_s;
    logic           eop_r, eop_s;
    logic [7:0]     sum_r, sum_s;
    logic [7:0]     cnt_r, cnt_s;
    logic [TW-1:0]  timer_r, timer_s;
    logic           pulse_r, pulse_s;
    logic [15:0]    frm_cnt_r, frm_cnt_s;
    logic           adv_s;
    logic           take_s;

    // Next-state and next-output computation; the output register only moves when it can advance.
    always_comb begin
        adv_s     = !vld_r || dout_rdy;
        state_s   = state_r;
        dout_s    = dout_r;
        vld_s     = vld_r;
        sop_s     = sop_r;
        eop_s     = eop_r;
        sum_s     = sum_r;
        cnt_s     = cnt_r;
        timer_s   = timer_r;
        pulse_s   = 1'b0;
        take_s    = 1'b0;
        frm_cnt_s = frm_cnt_r;

        if (vld_r && dout_rdy && eop_r) begin
            frm_cnt_s = frm_cnt_r + 16'd1;
        end else begin
            frm_cnt_s = frm_cnt_r;
        end

        if (adv_s) begin
            // Nothing loaded this cycle unless a state below says otherwise.
            vld_s = 1'b0;
            sop_s = 1'b0;
            eop_s = 1'b0;
            case (state_r)
                S_IDLE: begin
                    // Peek only: the first payload byte stays in the FIFO.
                    if (din_vld) begin
                        dout_s  = 8'h55;
                        vld_s   = 1'b1;
                        sop_s   = 1'b1;
                        state_s = S_H1;
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_H1: begin
                    dout_s  = 8'hD5;
                    vld_s   = 1'b1;
                    state_s = S_LEN;
                end
                S_LEN: begin
                    dout_s  = LEN_BYTE;
                    vld_s   = 1'b1;
                    cnt_s   = 8'd0;
                    sum_s   = 8'd0;
                    timer_s = '0;
                    state_s = S_DATA;
                end
                S_DATA: begin
                    take_s = 1'b1;
                    if (din_vld) begin
                        dout_s  = din;
                        vld_s   = 1'b1;
                        sum_s   = csum_add(sum_r, din);
                        cnt_s   = cnt_r + 8'd1;
                        timer_s = '0;
                        if (cnt_r == LAST_IDX) begin
                            state_s = S_CSUM;
                        end else begin
                            state_s = S_DATA;
                        end
                    end else begin
                        // Starved while the sink could take a byte: count toward padding.
                        timer_s = timer_r + TW'(1);
                        if (timer_r == TIMER_LAST) begin
                            state_s = S_PAD;
                            pulse_s = 1'b1;
                        end else begin
                            state_s = S_DATA;
                        end
                    end
                end
                S_PAD: begin
                    dout_s = PAD_BYTE;
                    vld_s  = 1'b1;
                    sum_s  = csum_add(sum_r, PAD_BYTE);
                    cnt_s  = cnt_r + 8'd1;
                    if (cnt_r == LAST_IDX) begin
                        state_s = S_CSUM;
                    end else begin
                        state_s = S_PAD;
                    end
                end
                S_CSUM: begin
                    dout_s  = sum_r;
                    vld_s   = 1'b1;
                    eop_s   = 1'b1;
                    state_s = S_IDLE;
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end else begin
            // Sink stalled: every register holds, nothing consumed.
            state_s = state_r;
        end
    end

    // Upstream ready is only offered while collecting payload and never during reset.
    assign din_rdy = take_s && !rst;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Output register, checksum/count/timer datapath and frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_r    <= 8'd0;
            vld_r     <= 1'b0;
            sop_r     <= 1'b0;
            eop_r     <= 1'b0;
            sum_r     <= 8'd0;
            cnt_r     <= 8'd0;
            timer_r   <= '0;
            pulse_r   <= 1'b0;
            frm_cnt_r <= 16'd0;
        end else begin
            dout_r    <= dout_s;
            vld_r     <= vld_s;
            sop_r     <= sop_s;
            eop_r     <= eop_s;
            sum_r     <= sum_s;
            cnt_r     <= cnt_s;
            timer_r   <= timer_s;
            pulse_r   <= pulse_s;
            frm_cnt_r <= frm_cnt_s;
        end
    end

    assign dout          = dout_r;
    assign dout_vld      = vld_r;
    assign dout_sop      = sop_r;
    assign dout_eop      = eop_r;
    assign frm_cnt       = frm_cnt_r;
    assign timeout_pulse = pulse_r;

endmodule

// File: tb/tb_byte_frame_packer.sv
// Testbench for byte_frame_packer: directed frames, stalls, padding, reset,
// back-to-back long frames and a randomized stream checked against a
// frame-level reference model (header, payload, pad fill, modulo-256 sum).

module tb_byte_frame_packer;

    localparam int         A_LEN = 4;
    localparam int         A_TO  = 3;
    localparam int         B_LEN = 16;
    localparam int         B_TO  = 64;
    localparam logic [7:0] PAD   = 8'h00;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  din_a, dout_a, din_b, dout_b;
    logic        din_vld_a, din_rdy_a, dout_vld_a, sop_a, eop_a, dout_rdy_a, pulse_a;
    logic        din_vld_b, din_rdy_b, dout_vld_b, sop_b, eop_b, dout_rdy_b, pulse_b;
    logic [15:0] frm_cnt_a, frm_cnt_b;

    byte_frame_packer #(.PKT_LEN(A_LEN), .TIMEOUT(A_TO), .PAD_BYTE(PAD)) dut_a (
        .clk(clk), .rst(rst), .din(din_a), .din_vld(din_vld_a), .din_rdy(din_rdy_a),
        .dout(dout_a), .dout_vld(dout_vld_a), .dout_sop(sop_a), .dout_eop(eop_a),
        .dout_rdy(dout_rdy_a), .frm_cnt(frm_cnt_a), .timeout_pulse(pulse_a)
    );

    byte_frame_packer #(.PKT_LEN(B_LEN), .TIMEOUT(B_TO), .PAD_BYTE(PAD)) dut_b (
        .clk(clk), .rst(rst), .din(din_b), .din_vld(din_vld_b), .din_rdy(din_rdy_b),
        .dout(dout_b), .dout_vld(dout_vld_b), .dout_sop(sop_b), .dout_eop(eop_b),
        .dout_rdy(dout_rdy_b), .frm_cnt(frm_cnt_b), .timeout_pulse(pulse_b)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [9:0] exp_q[$];   // {sop, eop, byte} in transfer order
    logic [7:0] src_q[$];   // payload bytes still to be offered to dut_a
    int frames_done;
    int tick_no = 0;
    bit last_in_hs, last_out_hs;
    int out_count, first_out_tick, last_out_tick;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: header, LEN, payload padded to plen with PAD, then sum mod 256.
    function automatic void build_frame(input logic [7:0] pay[$], input int plen);
        logic [7:0] sum;
        logic [7:0] b;
        logic [7:0] lb;
        sum = 8'd0;
        lb  = 8'(plen);
        exp_q.push_back({2'b10, 8'h55});
        exp_q.push_back({2'b00, 8'hD5});
        exp_q.push_back({2'b00, lb});
        for (int i = 0; i < plen; i++) begin
            b   = (i < pay.size()) ? pay[i] : PAD;
            sum = 8'((int'(sum) + int'(b)) % 256);
            exp_q.push_back({2'b00, b});
        end
        exp_q.push_back({2'b01, sum});
    endfunction

    // One clock of dut_a: handshake sampling at negedge, post-edge checks at +1.
    task automatic tick(input logic exp_pulse);
        logic [7:0] held_d;
        logic       held_s, held_e;
        bit         stall;
        logic [9:0] e;
        @(negedge clk);
        stall       = dout_vld_a && !dout_rdy_a;
        last_in_hs  = din_vld_a && din_rdy_a;
        last_out_hs = dout_vld_a && dout_rdy_a;
        held_d = dout_a;
        held_s = sop_a;
        held_e = eop_a;
        if (stall) chk("rdy_while_stalled", 32'(din_rdy_a), 32'd0);
        if (last_out_hs) begin
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL dout_extra: observed byte %02h expected no transfer", dout_a);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("dout_seq", 32'({sop_a, eop_a, dout_a}), 32'(e));
                if (e[8]) frames_done++;
                if (out_count == 0) first_out_tick = tick_no;
                last_out_tick = tick_no;
                out_count++;
            end
        end
        if (last_in_hs && src_q.size() > 0) void'(src_q.pop_front());
        @(posedge clk);
        #1;
        tick_no++;
        if (stall) begin
            chk("stall_vld", 32'(dout_vld_a), 32'd1);
            chk("stall_hold", 32'({sop_a, eop_a, dout_a}), 32'({held_s, held_e, held_d}));
        end
        chk("frm_cnt", 32'(frm_cnt_a), 32'(frames_done));
        chk("timeout_pulse", 32'(pulse_a), 32'(exp_pulse));
    endtask

    // One-cycle reset with whatever inputs are currently applied.
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_no_consume", 32'(din_rdy_a), 32'd0);
        @(posedge clk);
        #1;
        tick_no++;
        chk("rst_dout", 32'(dout_a), 32'd0);
        chk("rst_vld", 32'(dout_vld_a), 32'd0);
        chk("rst_sop_eop", 32'({sop_a, eop_a}), 32'd0);
        chk("rst_frm_cnt", 32'(frm_cnt_a), 32'd0);
        chk("rst_pulse", 32'(pulse_a), 32'd0);
        chk("rst_b_vld", 32'(dout_vld_b), 32'd0);
        rst = 1'b0;
        din_vld_a = 1'b0;
        #1;
        chk("rst_din_rdy", 32'(din_rdy_a), 32'd0);
        exp_q.delete();
        src_q.delete();
        frames_done = 0;
    endtask

    // Offer src_q to dut_a (valid held until accepted) until all expected bytes leave.
    // rdy_mode: 0 always ready, 1 toggling, 2 random. Random gaps never exceed two cycles.
    task automatic run_stream(input int rdy_mode, input bit gaps, input int budget);
        int gap = 0;
        int n = 0;
        bit tog = 1'b1;
        while (exp_q.size() > 0 && n < budget) begin
            if (!din_vld_a) begin
                if (src_q.size() > 0 && (!gaps || gap >= 2 || $urandom_range(0, 3) != 0)) begin
                    din_vld_a = 1'b1;
                    din_a     = src_q[0];
                    gap       = 0;
                end else begin
                    gap++;
                end
            end
            case (rdy_mode)
                0:       dout_rdy_a = 1'b1;
                1:       begin dout_rdy_a = tog; tog = !tog; end
                default: dout_rdy_a = ($urandom_range(0, 9) < 6);
            endcase
            tick(1'b0);
            if (last_in_hs) din_vld_a = 1'b0;
            n++;
        end
        chk("stream_done", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] p[$];
        logic [9:0] e;
        int start, k, next_b, n, first_b, last_b, outs_b;

        rst = 1'b1;
        din_a = 8'd0; din_vld_a = 1'b0; dout_rdy_a = 1'b1;
        din_b = 8'd0; din_vld_b = 1'b0; dout_rdy_b = 1'b1;
        frames_done = 0;
        out_count = 0;
        do_reset();

        // T6: idle source never starts a frame or times out.
        for (int i = 0; i < 40; i++) begin
            dout_rdy_a = ($urandom_range(0, 1) == 1);
            tick(1'b0);
            chk("t6_vld", 32'(dout_vld_a), 32'd0);
            chk("t6_din_rdy", 32'(din_rdy_a), 32'd0);
        end

        // T4: reset after the second payload byte drops the frame.
        p = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        src_q = p;
        build_frame(p, A_LEN);
        dout_rdy_a = 1'b1;
        k = 0; n = 0;
        while (k < 2 && n < 30) begin
            din_vld_a = 1'b1;
            din_a     = src_q[0];
            tick(1'b0);
            if (last_in_hs) k++;
            n++;
        end
        chk("t4_accepted", 32'(k), 32'd2);
        din_vld_a = 1'b1;
        din_a     = src_q[0];
        do_reset();
        p = '{8'h5A, 8'hC3, 8'h01, 8'hFE};
        src_q = p;
        build_frame(p, A_LEN);
        run_stream(0, 1'b0, 40);
        chk("t4_frm_cnt", 32'(frm_cnt_a), 32'd1);

        // T1: continuous source and sink, eight bytes on eight consecutive cycles.
        do_reset();
        p = '{8'h03, 8'hE8, 8'h03, 8'hE9};
        src_q = p;
        build_frame(p, A_LEN);
        out_count = 0;
        start = tick_no;
        run_stream(0, 1'b0, 40);
        chk("t1_latency", 32'(first_out_tick - start), 32'd1);
        chk("t1_span", 32'(last_out_tick - first_out_tick + 1), 32'd8);
        chk("t1_frm_cnt", 32'(frm_cnt_a), 32'd1);

        // T2: same frame with the sink toggling ready.
        p = '{8'h03, 8'hE8, 8'h03, 8'hE9};
        src_q = p;
        build_frame(p, A_LEN);
        run_stream(1, 1'b0, 60);
        chk("t2_frm_cnt", 32'(frm_cnt_a), 32'd2);

        // T3: two bytes then starvation; pulse on the third starved cycle, then pad.
        do_reset();
        p = '{8'h10, 8'h20};
        src_q = p;
        build_frame(p, A_LEN);
        dout_rdy_a = 1'b1;
        n = 0;
        while (src_q.size() > 0 && n < 30) begin
            din_vld_a = 1'b1;
            din_a     = src_q[0];
            tick(1'b0);
            n++;
        end
        din_vld_a = 1'b0;
        k = 0;
        while (exp_q.size() > 0 && k < 40) begin
            k++;
            tick(k == A_TO);
        end
        chk("t3_done", 32'(exp_q.size()), 32'd0);
        chk("t3_frm_cnt", 32'(frm_cnt_a), 32'd1);

        // Randomized stream: random payloads, source gaps and sink backpressure.
        do_reset();
        for (int i = 0; i < 12 * A_LEN; i++) src_q.push_back(8'($urandom_range(0, 255)));
        for (int f = 0; f < 12; f++) begin
            p.delete();
            for (int i = 0; i < A_LEN; i++) p.push_back(src_q[f * A_LEN + i]);
            build_frame(p, A_LEN);
        end
        run_stream(2, 1'b1, 3000);
        for (int i = 0; i < 5; i++) begin
            dout_rdy_a = 1'b1;
            tick(1'b0);
            chk("rand_idle_vld", 32'(dout_vld_a), 32'd0);
        end
        chk("rand_frm_cnt", 32'(frm_cnt_a), 32'd12);

        // T5: 16-byte frames, 0x00..0x1F continuous, two frames back to back.
        exp_q.delete();
        p.delete();
        for (int i = 0; i < 16; i++) p.push_back(8'(i));
        build_frame(p, B_LEN);
        p.delete();
        for (int i = 16; i < 32; i++) p.push_back(8'(i));
        build_frame(p, B_LEN);
        next_b = 0; n = 0; first_b = -1; last_b = 0; outs_b = 0;
        din_vld_b = 1'b1; din_b = 8'd0; dout_rdy_b = 1'b1;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            if (dout_vld_b && dout_rdy_b) begin
                e = exp_q.pop_front();
                chk("t5_byte", 32'({sop_b, eop_b, dout_b}), 32'(e));
                if (eop_b) chk("t5_csum", 32'(dout_b), 32'h78);
                if (first_b < 0) first_b = n;
                last_b = n;
                outs_b++;
            end
            if (din_vld_b && din_rdy_b) next_b++;
            @(posedge clk);
            #1;
            n++;
            din_vld_b = (next_b < 32);
            din_b     = 8'(next_b);
        end
        chk("t5_done", 32'(exp_q.size()), 32'd0);
        chk("t5_count", 32'(outs_b), 32'd40);
        chk("t5_span", 32'(last_b - first_b + 1), 32'd40);
        chk("t5_frm_cnt", 32'(frm_cnt_b), 32'd2);
        chk("t5_no_pulse", 32'(pulse_b), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
